// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern mode encodings and standard timing sets.
// Pure declarations; no latency and no flow control.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK    = 2'd0,
    MODE_GRADIENT = 2'd1,
    MODE_BARS     = 2'd2,
    MODE_CHECKER  = 2'd3
  } mode_e;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  // 800x600@60, 40 MHz pixel clock (both syncs active-high)
  localparam int SVGA_H_VIS  = 800;
  localparam int SVGA_H_FP   = 40;
  localparam int SVGA_H_SYNC = 128;
  localparam int SVGA_H_BP   = 88;
  localparam int SVGA_V_VIS  = 600;
  localparam int SVGA_V_FP   = 1;
  localparam int SVGA_V_SYNC = 4;
  localparam int SVGA_V_BP   = 23;

  // Width of one colour bar; clamped so tiny test timings still count.
  function automatic int bar_width(input int h_vis);
    return (h_vis / 8 < 1) ? 1 : h_vis / 8;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern source for one pixel position; zero latency.
// No flow control: the caller registers the result and masks it during blanking.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W    = 3,
  parameter int CHECK_LOG2 = 5,
  parameter int X_W        = 10,
  parameter int Y_W        = 10
) (
  input  mode_e              mode,
  input  logic [X_W-1:0]     h,
  input  logic [Y_W-1:0]     v,
  input  logic [2:0]         bar,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  logic chk;

  always_comb begin
    red   = '0;
    green = '0;
    blue  = '0;
    // Counters are zero-extended first so slices above their width read as 0.
    chk   = 1'((32'(h) >> CHECK_LOG2) ^ (32'(v) >> CHECK_LOG2));
    case (mode)
      MODE_GRADIENT: begin
        red   = COLOR_W'(32'(v) >> 4);
        green = COLOR_W'(32'(v) >> 3);
        blue  = COLOR_W'(32'(h) >> 5);
      end
      MODE_BARS: begin
        red   = {COLOR_W{bar[2]}};
        green = {COLOR_W{bar[1]}};
        blue  = {COLOR_W{bar[0]}};
      end
      MODE_CHECKER: begin
        red   = {COLOR_W{chk}};
        green = {COLOR_W{chk}};
        blue  = {COLOR_W{chk}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vga_timing_pattern.sv
// Parametrised VGA/DVI timing generator with selectable test pattern; outputs registered, 1 enabled cycle.
// pix_ce=0 freezes every counter and output; mode changes only land on frame boundaries.
module vga_timing_pattern
  import vga_pkg::*;
#(
  parameter int H_VIS      = VGA_H_VIS,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_VIS      = VGA_V_VIS,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 3,
  parameter int CHECK_LOG2 = 5,
  localparam int H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP,
  localparam int X_W       = $clog2(H_TOTAL),
  localparam int Y_W       = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_ce,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               frame_start,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y
);

  localparam int BAR_W    = bar_width(H_VIS);
  localparam int BC_W     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = H_VIS + H_FP + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = V_VIS + V_FP + V_SYNC;

  logic [X_W-1:0]     h_q, h_d;
  logic [Y_W-1:0]     v_q, v_d;
  mode_e              mode_q, mode_d;
  logic [2:0]         bar_q, bar_d;
  logic [BC_W-1:0]    bcnt_q, bcnt_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic               blank_q, blank_d, frame_start_q, frame_start_d;
  logic [X_W-1:0]     pix_x_q, pix_x_d;
  logic [Y_W-1:0]     pix_y_q, pix_y_d;

  logic               h_last, v_last, hs_act, vs_act, vis;
  logic [COLOR_W-1:0] pat_red, pat_green, pat_blue;

  assign h_last = (int'(h_q) == H_TOTAL - 1);
  assign v_last = (int'(v_q) == V_TOTAL - 1);
  assign hs_act = (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
  assign vs_act = (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);
  assign vis    = (int'(h_q) < H_VIS) && (int'(v_q) < V_VIS);

  vga_pattern_gen #(
    .COLOR_W    (COLOR_W),
    .CHECK_LOG2 (CHECK_LOG2),
    .X_W        (X_W),
    .Y_W        (Y_W)
  ) u_pattern (
    .mode  (mode_q),
    .h     (h_q),
    .v     (v_q),
    .bar   (bar_q),
    .red   (pat_red),
    .green (pat_green),
    .blue  (pat_blue)
  );

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    mode_d        = mode_q;
    bar_d         = bar_q;
    bcnt_d        = bcnt_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    frame_start_d = frame_start_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;

    if (pix_ce) begin
      if (h_last) begin
        h_d = '0;
        if (v_last) begin
          v_d    = '0;
          mode_d = mode_e'(mode);
        end else begin
          v_d = v_q + Y_W'(1);
        end
      end else begin
        h_d = h_q + X_W'(1);
      end

      // Bar state tracks the next h value so bar_q always matches h_q.
      if (h_last) begin
        bar_d  = '0;
        bcnt_d = '0;
      end else if (int'(bcnt_q) == BAR_W - 1) begin
        bcnt_d = '0;
        if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
      end else begin
        bcnt_d = bcnt_q + BC_W'(1);
      end

      red_d         = vis ? pat_red   : '0;
      green_d       = vis ? pat_green : '0;
      blue_d        = vis ? pat_blue  : '0;
      hsync_d       = hs_act ? HS_POL : ~HS_POL;
      vsync_d       = vs_act ? VS_POL : ~VS_POL;
      blank_d       = ~vis;
      frame_start_d = (h_q == '0) && (v_q == '0);
      pix_x_d       = h_q;
      pix_y_d       = v_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      mode_q        <= MODE_BLACK;
      bar_q         <= '0;
      bcnt_q        <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      mode_q        <= mode_d;
      bar_q         <= bar_d;
      bcnt_q        <= bcnt_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;

endmodule
